// File: rtl/d6t_pkg.sv
// Shared constants, steer codes, FSM encoding and steer decision for the D6T thermal frame processor.
package d6t_pkg;

  localparam logic [6:0]  SENSOR_ADDR = 7'h0A;
  localparam logic [7:0]  CMD_READ    = 8'h4C;
  localparam logic [7:0]  CRC_POLY    = 8'h07;
  localparam int unsigned N_PIX       = 8;
  localparam int unsigned FRAME_BYTES = 18;
  localparam int unsigned CRC_BYTES   = FRAME_BYTES + 3;

  typedef enum logic [1:0] {
    STEER_NONE   = 2'b00,
    STEER_LEFT   = 2'b01,
    STEER_CENTRE = 2'b10,
    STEER_RIGHT  = 2'b11
  } steer_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CRC   = 3'd2,
    S_CHECK = 3'd3,
    S_SCAN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // A cold scene never steers; otherwise the hottest pixel's position picks the direction.
  function automatic steer_t steer_of(input logic [2:0] idx, input logic signed [15:0] temp,
                                      input logic signed [15:0] hot_min,
                                      input logic [2:0] lo, input logic [2:0] hi);
    if (temp < hot_min) return STEER_NONE;
    if (idx < lo)       return STEER_LEFT;
    if (idx > hi)       return STEER_RIGHT;
    return STEER_CENTRE;
  endfunction

endpackage

// File: rtl/d6t_crc8_step.sv
// Byte-wide SMBus CRC-8 update (MSB first, no reflection).
module crc8_step
  import d6t_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[7] ? ((crc_out << 1) ^ CRC_POLY) : (crc_out << 1);
    end
  end

endmodule

// File: rtl/d6t_frame_proc.sv
// Captures a D6T frame from the I2C reader, verifies its PEC, finds the hottest pixel
// and reports a steer code to the repositioning controller.
module d6t_frame_proc
  import d6t_pkg::*;
#(
  parameter logic signed [15:0] HOT_MIN   = 16'sd300,
  parameter int unsigned        CENTER_LO = 3,
  parameter int unsigned        CENTER_HI = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_valid,
  input  logic [15:0]  ptat_in,
  input  logic [127:0] pix_in,
  input  logic [7:0]   pec_in,
  output logic         busy,
  output logic         result_valid,
  output logic         pec_ok,
  output logic [15:0]  ptat_out,
  output logic [2:0]   hot_idx,
  output logic [15:0]  hot_temp,
  output logic [1:0]   steer,
  output logic [7:0]   err_cnt,
  output logic         overrun
);

  localparam int unsigned BUF_W = FRAME_BYTES * 8;

  state_t                   state_q, state_d;
  logic [2:0]               sync_q;
  logic                     fv_edge;
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic [7:0]               pec_q, pec_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [7:0]               crc_q, crc_d, crc_next, crc_byte;
  logic [4:0]               boff;
  logic [2:0]               scan_idx, best_idx_q, best_idx_d;
  logic [7:0]               pix_off;
  logic signed [15:0]       pix_cur, best_val_q, best_val_d;
  logic                     busy_q, busy_d, rv_q, rv_d, pec_ok_q, pec_ok_d, ovr_q, ovr_d;
  logic [15:0]              ptat_q, ptat_d;
  logic [2:0]               hidx_q, hidx_d;
  logic signed [15:0]       htemp_q, htemp_d;
  steer_t                   steer_q, steer_d;
  logic [7:0]               err_q, err_d;

  // Two synchroniser flops plus one delay flop for the rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], frame_valid};
  end
  assign fv_edge = sync_q[1] & ~sync_q[2];

  // CRC stream: three SMBus header bytes, then the captured frame bytes in order.
  always_comb begin
    boff = 5'(cnt_q - 5'd3);
    case (cnt_q)
      5'd0:    crc_byte = {SENSOR_ADDR, 1'b0};
      5'd1:    crc_byte = CMD_READ;
      5'd2:    crc_byte = {SENSOR_ADDR, 1'b1};
      default: crc_byte = buf_q[{boff, 3'b000} +: 8];
    endcase
  end

  crc8_step u_crc (.crc_in(crc_q), .byte_in(crc_byte), .crc_out(crc_next));

  assign scan_idx = cnt_q[2:0];
  assign pix_off  = 8'({scan_idx, 4'b0000}) + 8'd16;
  assign pix_cur  = buf_q[pix_off +: 16];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fv_edge) state_d = S_LOAD;
      S_LOAD:  state_d = S_CRC;
      S_CRC:   if (cnt_q == 5'(CRC_BYTES - 1)) state_d = S_CHECK;
      S_CHECK: state_d = (crc_q == pec_q) ? S_SCAN : S_DONE;
      S_SCAN:  if (scan_idx == 3'(N_PIX - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Results are registered on entry to DONE so they appear together with the result_valid pulse.
  always_comb begin
    buf_d      = buf_q;
    pec_d      = pec_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    busy_d     = (state_d != S_IDLE);
    rv_d       = 1'b0;
    pec_ok_d   = pec_ok_q;
    ptat_d     = ptat_q;
    hidx_d     = hidx_q;
    htemp_d    = htemp_q;
    steer_d    = steer_q;
    err_d      = err_q;
    ovr_d      = ovr_q | (fv_edge & (state_q != S_IDLE));
    case (state_q)
      S_LOAD: begin
        buf_d = {pix_in, ptat_in};
        pec_d = pec_in;
        cnt_d = '0;
        crc_d = '0;
      end
      S_CRC: begin
        crc_d = crc_next;
        cnt_d = cnt_q + 5'd1;
      end
      S_CHECK: begin
        cnt_d = '0;
        if (crc_q != pec_q) begin
          pec_ok_d = 1'b0;
          rv_d     = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      S_SCAN: begin
        cnt_d = cnt_q + 5'd1;
        if ((scan_idx == 3'd0) || (pix_cur > best_val_q)) begin
          best_idx_d = scan_idx;
          best_val_d = pix_cur;
        end
        if (scan_idx == 3'(N_PIX - 1)) begin
          rv_d     = 1'b1;
          pec_ok_d = 1'b1;
          ptat_d   = buf_q[15:0];
          hidx_d   = best_idx_d;
          htemp_d  = best_val_d;
          steer_d  = steer_of(best_idx_d, best_val_d, HOT_MIN, 3'(CENTER_LO), 3'(CENTER_HI));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      pec_q      <= '0;
      cnt_q      <= '0;
      crc_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      pec_ok_q   <= 1'b0;
      ptat_q     <= '0;
      hidx_q     <= '0;
      htemp_q    <= '0;
      steer_q    <= STEER_NONE;
      err_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      pec_q      <= pec_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      pec_ok_q   <= pec_ok_d;
      ptat_q     <= ptat_d;
      hidx_q     <= hidx_d;
      htemp_q    <= htemp_d;
      steer_q    <= steer_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign pec_ok       = pec_ok_q;
  assign ptat_out     = ptat_q;
  assign hot_idx      = hidx_q;
  assign hot_temp     = htemp_q;
  assign steer        = steer_q;
  assign err_cnt      = err_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_d6t_frame_proc.sv
// Directed scoreboard bench for d6t_frame_proc: golden bit-serial CRC, argmax and steer model.
`timescale 1ns/1ps
module tb_d6t_frame_proc;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_valid;
  logic [15:0]  ptat_in;
  logic [127:0] pix_in;
  logic [7:0]   pec_in;
  logic         busy, result_valid, pec_ok, overrun;
  logic [15:0]  ptat_out, hot_temp;
  logic [2:0]   hot_idx;
  logic [1:0]   steer;
  logic [7:0]   err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pec_ok;
    logic [15:0] ptat;
    logic [2:0]  idx;
    logic [15:0] temp;
    logic [1:0]  steer;
    logic [7:0]  err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic [15:0] m_ptat, m_temp;
  logic [2:0]  m_idx;
  logic [1:0]  m_steer;
  logic [7:0]  m_err;

  always #5 clk = ~clk;

  d6t_frame_proc dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .ptat_in(ptat_in), .pix_in(pix_in),
    .pec_in(pec_in), .busy(busy), .result_valid(result_valid), .pec_ok(pec_ok),
    .ptat_out(ptat_out), .hot_idx(hot_idx), .hot_temp(hot_temp), .steer(steer),
    .err_cnt(err_cnt), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] frame_pec(input logic [15:0] ptat, input logic [127:0] pix);
    logic [7:0] c;
    c = 8'h00;
    c = crc_bit(c, 8'h14);
    c = crc_bit(c, 8'h4C);
    c = crc_bit(c, 8'h15);
    c = crc_bit(c, ptat[7:0]);
    c = crc_bit(c, ptat[15:8]);
    for (int i = 0; i < 16; i++) c = crc_bit(c, pix[8*i +: 8]);
    return c;
  endfunction

  function automatic logic [1:0] model_steer(input logic [2:0] idx, input logic signed [15:0] t);
    if (t < 16'sd300) return 2'b00;
    if (idx < 3'd3)   return 2'b01;
    if (idx > 3'd4)   return 2'b11;
    return 2'b10;
  endfunction

  function automatic logic [127:0] pk(input int p0, input int p1, input int p2, input int p3,
                                      input int p4, input int p5, input int p6, input int p7);
    return {16'(p7), 16'(p6), 16'(p5), 16'(p4), 16'(p3), 16'(p2), 16'(p1), 16'(p0)};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_rv"},    32'(result_valid), 32'd0);
    chk({tag, "_pecok"}, 32'(pec_ok), 32'd0);
    chk({tag, "_ptat"},  32'(ptat_out), 32'd0);
    chk({tag, "_idx"},   32'(hot_idx), 32'd0);
    chk({tag, "_temp"},  32'(hot_temp), 32'd0);
    chk({tag, "_steer"}, 32'(steer), 32'd0);
    chk({tag, "_err"},   32'(err_cnt), 32'd0);
    chk({tag, "_ovr"},   32'(overrun), 32'd0);
  endtask

  // Drives one frame (optionally a second valid rise while busy) and scores its single result.
  task automatic run_frame(input string tag, input logic [15:0] ptat, input logic [127:0] pix,
                           input logic [7:0] pec_xor, input bit double_rise);
    exp_t               e;
    int                 pulses;
    logic signed [15:0] best;
    logic [2:0]         bi;
    pulses = 0;
    if (pec_xor == 8'h00) begin
      bi   = 3'd0;
      best = pix[15:0];
      for (int i = 1; i < 8; i++) begin
        if ($signed(pix[16*i +: 16]) > best) begin
          best = pix[16*i +: 16];
          bi   = 3'(i);
        end
      end
      m_ptat   = ptat;
      m_idx    = bi;
      m_temp   = best;
      m_steer  = model_steer(bi, best);
      e.pec_ok = 1'b1;
      e.lat    = 34;
    end else begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      e.pec_ok = 1'b0;
      e.lat    = 26;
    end
    e.ptat  = m_ptat;
    e.idx   = m_idx;
    e.temp  = m_temp;
    e.steer = m_steer;
    e.err   = m_err;
    sb.push_back(e);
    ptat_in     = ptat;
    pix_in      = pix;
    pec_in      = frame_pec(ptat, pix) ^ pec_xor;
    frame_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 4) frame_valid = 1'b0;
      if (double_rise && c == 12) frame_valid = 1'b1;
      if (double_rise && c == 16) frame_valid = 1'b0;
      if (c == 10) chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
      if (result_valid) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_latency"}, 32'(c), 32'(e.lat));
          chk({tag, "_pec_ok"},  32'(pec_ok), 32'(e.pec_ok));
          chk({tag, "_ptat"},    32'(ptat_out), 32'(e.ptat));
          chk({tag, "_hot_idx"}, 32'(hot_idx), 32'(e.idx));
          chk({tag, "_hot_temp"},32'(hot_temp), 32'(e.temp));
          chk({tag, "_steer"},   32'(steer), 32'(e.steer));
          chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
        end
      end
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    sb.delete();
  endtask

  initial begin
    int pulses;
    rst         = 1'b1;
    frame_valid = 1'b0;
    ptat_in     = '0;
    pix_in      = '0;
    pec_in      = '0;
    m_ptat = '0; m_temp = '0; m_idx = '0; m_steer = '0; m_err = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("post_reset");

    run_frame("t1_good", 16'd250, pk(100, 200, 900, 300, 50, 60, 70, 80), 8'h00, 1'b0);
    chk("t1_overrun", 32'(overrun), 32'd0);
    run_frame("t2_bad", 16'd250, pk(100, 200, 900, 300, 50, 60, 70, 80), 8'h01, 1'b0);
    run_frame("t3_cold", 16'd251, pk(250, 250, 250, 250, 250, 250, 250, 250), 8'h00, 1'b0);
    run_frame("t3_tie", 16'd252, pk(250, 250, 250, 700, 700, 250, 250, 250), 8'h00, 1'b0);
    run_frame("t4_signed", 16'd253, pk(-256, -256, -256, -256, -256, -256, -256, 1024), 8'h00, 1'b0);
    run_frame("t5_overrun", 16'd254, pk(10, 400, 20, 30, 40, 50, 60, 70), 8'h00, 1'b1);
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 256; i++)
      run_frame("t5_sat", 16'd254, pk(10, 400, 20, 30, 40, 50, 60, 70), 8'h80, 1'b0);
    chk("t5_err_sat", 32'(err_cnt), 32'd255);
    chk("t5_overrun_sticky", 32'(overrun), 32'd1);

    // Reset lands while the scan is in progress; the frame must vanish without a result.
    pulses      = 0;
    ptat_in     = 16'd300;
    pix_in      = pk(1, 2, 3, 4, 5, 6, 7, 8);
    pec_in      = frame_pec(16'd300, pk(1, 2, 3, 4, 5, 6, 7, 8));
    frame_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 4) frame_valid = 1'b0;
      if (c == 20) chk("t6_busy_before_rst", 32'(busy), 32'd1);
      if (result_valid) pulses++;
      if (c == 28) rst = 1'b1;
      if (c == 29) begin
        check_zero("t6_rst");
        rst = 1'b0;
      end
    end
    chk("t6_no_result", 32'(pulses), 32'd0);
    m_ptat = '0; m_temp = '0; m_idx = '0; m_steer = '0; m_err = '0;

    run_frame("t6_after", 16'd333, pk(10, 20, 30, 40, 50, 60, 2000, 5), 8'h00, 1'b0);
    chk("t6_overrun_clear", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
